// File: rtl/dmem_access_ctrl_pkg.sv
// Shared constants and helpers for the data-memory access controller.
package dmem_access_ctrl_pkg;

    // Load modes as encoded by the MEM-stage decode.
    localparam logic [2:0] LT_NONE = 3'd0;
    localparam logic [2:0] LT_LB   = 3'd1;
    localparam logic [2:0] LT_LH   = 3'd2;
    localparam logic [2:0] LT_LW   = 3'd3;
    localparam logic [2:0] LT_LBU  = 3'd4;
    localparam logic [2:0] LT_LHU  = 3'd5;

    // Store sizes.
    localparam logic [1:0] SS_NONE = 2'd0;
    localparam logic [1:0] SS_SB   = 2'd1;
    localparam logic [1:0] SS_SH   = 2'd2;
    localparam logic [1:0] SS_SW   = 2'd3;

    // Access widths in bytes.
    localparam int unsigned BYTES_B = 1;
    localparam int unsigned BYTES_H = 2;
    localparam int unsigned BYTES_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StAcc0,
        StAcc1,
        StDone
    } state_e;

    // Right-aligned byte mask for the access width.
    function automatic logic [3:0] width_mask(input logic we, input logic [2:0] load_type,
                                              input logic [1:0] store_size);
        int unsigned nbytes;
        nbytes = BYTES_B;
        if (we) begin
            if (store_size == SS_SH) nbytes = BYTES_H;
            else if (store_size == SS_SW) nbytes = BYTES_W;
        end else begin
            if (load_type == LT_LH || load_type == LT_LHU) nbytes = BYTES_H;
            else if (load_type == LT_LW) nbytes = BYTES_W;
        end
        case (nbytes)
            BYTES_H: width_mask = 4'b0011;
            BYTES_W: width_mask = 4'b1111;
            default: width_mask = 4'b0001;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Shifts the two returned words down to the access offset and extends per load type.
module dmem_lane_merge
    import dmem_access_ctrl_pkg::*;
(
    input  logic [63:0] rd64,
    input  logic [1:0]  off,
    input  logic [2:0]  load_type,
    output logic [31:0] result
);

    logic [63:0] shifted;

    assign shifted = rd64 >> {off, 3'b000};

    // Extend the aligned low bytes according to the load mode.
    always_comb begin
        result = shifted[31:0];
        case (load_type)
            LT_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
            LT_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
            LT_LBU:  result = {24'h000000, shifted[7:0]};
            LT_LHU:  result = {16'h0000, shifted[15:0]};
            default: result = shifted[31:0];
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store sequencer for a word-organised req/ack data memory.
// Word-crossing accesses are split into two word transactions.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              req_we,
    input  logic [2:0]        req_load_type,
    input  logic [1:0]        req_store_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall_o,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_wbe,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned WA_W  = ADDR_W - 2;
    localparam int unsigned TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_INIT = TMO_W'(TIMEOUT);

    state_e           state_q;
    logic             we_q;
    logic [2:0]       lt_q;
    logic [1:0]       off_q;
    logic [3:0]       hi_be_q;
    logic [31:0]      hi_wd_q;
    logic [31:0]      rdata0_q;
    logic [TMO_W-1:0] tmo_q;

    logic             valid_req;
    logic [7:0]       be8;
    logic [63:0]      wd64;
    logic [63:0]      wdm;
    logic             in_acc;
    logic             need2;
    logic             tmo_hit;
    logic             finish;
    logic [63:0]      merge_in;
    logic [31:0]      merged;

    assign valid_req = req && (req_we ? (req_store_size != SS_NONE)
                                      : (req_load_type >= LT_LB && req_load_type <= LT_LHU));
    assign be8  = 8'(width_mask(req_we, req_load_type, req_store_size)) << req_addr[1:0];
    assign wd64 = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};

    // Keep only the written byte lanes; loads drive no write data.
    always_comb begin
        wdm = '0;
        for (int i = 0; i < 8; i++) begin
            wdm[8*i +: 8] = (req_we && be8[i]) ? wd64[8*i +: 8] : 8'h00;
        end
    end

    assign in_acc  = (state_q == StAcc0) || (state_q == StAcc1);
    assign need2   = (state_q == StAcc0) && (hi_be_q != 4'b0000);
    assign tmo_hit = (TIMEOUT > 0) && (tmo_q == TMO_W'(1));
    assign finish  = (mem_ack && !need2) || (!mem_ack && tmo_hit);

    // A single-word access merges straight from the bus; the split case pairs with word 0.
    assign merge_in = (state_q == StAcc0) ? {32'h0, mem_rdata} : {mem_rdata, rdata0_q};

    dmem_lane_merge u_merge (
        .rd64      (merge_in),
        .off       (off_q),
        .load_type (lt_q),
        .result    (merged)
    );

    // Stall through acceptance and both memory phases; DONE lets the pipeline advance.
    assign stall_o = !rst && (((state_q == StIdle) && valid_req) || in_acc);

    // Access sequencer with registered memory-port and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            lt_q       <= LT_NONE;
            off_q      <= 2'b00;
            hi_be_q    <= 4'b0000;
            hi_wd_q    <= 32'h0;
            rdata0_q   <= 32'h0;
            tmo_q      <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wbe    <= 4'b0000;
            mem_wdata  <= 32'h0;
        end else begin
            case (state_q)
                StIdle: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                    if (valid_req) begin
                        we_q      <= req_we;
                        lt_q      <= req_load_type;
                        off_q     <= req_addr[1:0];
                        hi_be_q   <= req_we ? be8[7:4] : 4'b0000;
                        hi_wd_q   <= wdm[63:32];
                        tmo_q     <= TMO_INIT;
                        mem_req   <= 1'b1;
                        mem_we    <= req_we;
                        mem_addr  <= req_addr[ADDR_W-1:2];
                        mem_wbe   <= req_we ? be8[3:0] : 4'b0000;
                        mem_wdata <= wdm[31:0];
                        state_q   <= StAcc0;
                    end
                    // Loads keep the split decision too; hi_be_q only tracks store lanes.
                    if (valid_req && !req_we) hi_be_q <= be8[7:4];
                end
                StAcc0, StAcc1: begin
                    if (mem_ack && state_q == StAcc0) rdata0_q <= mem_rdata;
                    if (mem_ack && need2) begin
                        mem_addr  <= mem_addr + WA_W'(1);
                        mem_wbe   <= we_q ? hi_be_q : 4'b0000;
                        mem_wdata <= hi_wd_q;
                        tmo_q     <= TMO_INIT;
                        state_q   <= StAcc1;
                    end else if (finish) begin
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_wbe    <= 4'b0000;
                        mem_wdata  <= 32'h0;
                        resp_valid <= 1'b1;
                        resp_err   <= !mem_ack;
                        resp_rdata <= (mem_ack && !we_q) ? merged : 32'h0;
                        state_q    <= StDone;
                    end else if (!mem_ack) begin
                        tmo_q <= tmo_q - TMO_W'(1);
                    end
                end
                StDone: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: vector table plus multi-cycle corner sequences.
module tb_dmem_access_ctrl;
    import dmem_access_ctrl_pkg::*;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        req_we;
    logic [2:0]  req_load_type;
    logic [1:0]  req_store_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall_o;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_wbe;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    dmem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_we         (req_we),
        .req_load_type  (req_load_type),
        .req_store_size (req_store_size),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .stall_o        (stall_o),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wbe        (mem_wbe),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          t0;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [29:0] addr;
        logic        we;
        logic [3:0]  wbe;
        logic [31:0] wdata;
    } acc_t;
    acc_t acc_q[$];

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  lt;
        logic [1:0]  ss;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          lat;
        int          nacc;
        logic [29:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [29:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
    } vec_t;
    vec_t vecs[15];

    // Memory model: word array indexed by low word-address bits.
    logic [31:0] mem [256];
    int          ack_delay = 0;
    bit          no_ack    = 0;
    bit          nak_en    = 0;
    logic [29:0] nak_addr  = '0;

    task automatic init_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'h88776655;
        mem[8'h41] = 32'hCCBBAA99;
        mem[8'hFF] = 32'h12345678;
        mem[8'h00] = 32'hDEADBEEF;
    endtask

    // Responder: decides ack for the coming edge on each falling edge.
    initial begin
        int wcnt;
        logic [31:0] w;
        acc_t a;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (!rst && mem_req && !no_ack && !(nak_en && mem_addr == nak_addr)) begin
                if (wcnt >= ack_delay) begin
                    w = mem[mem_addr[7:0]];
                    mem_ack   = 1'b1;
                    mem_rdata = w;
                    if (mem_we) begin
                        for (int i = 0; i < 4; i++)
                            if (mem_wbe[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
                        mem[mem_addr[7:0]] = w;
                    end
                    a.addr = mem_addr; a.we = mem_we; a.wbe = mem_wbe; a.wdata = mem_wdata;
                    acc_q.push_back(a);
                    wcnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Scoreboard: every response pulse is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && resp_valid) begin
                if (sb_q.size() == 0) begin
                    check("resp_unexpected", 64'(resp_valid), 64'(0));
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_rdata"}, 64'(resp_rdata), 64'(e.rdata));
                    check({e.name, "_err"}, 64'(resp_err), 64'(e.err));
                    if (e.lat >= 0) check({e.name, "_latency"}, 64'(cyc - e.t0), 64'(e.lat));
                end
            end
        end
    end

    task automatic start_req(input string name, input logic we, input logic [2:0] lt,
                             input logic [1:0] ss, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] exp_rd, input logic exp_err, input int lat);
        exp_t e;
        @(posedge clk);
        #1;
        req = 1'b1; req_we = we; req_load_type = lt; req_store_size = ss;
        req_addr = addr; req_wdata = wd;
        acc_q.delete();
        e.name = name; e.rdata = exp_rd; e.err = exp_err; e.t0 = cyc; e.lat = lat;
        sb_q.push_back(e);
    endtask

    // Waits for resp_valid; counts mem_req cycles and checks stall and field stability.
    task automatic wait_resp(input string name, output int req_cycles, output bit got);
        bit stall_ok;
        bit stable_ok;
        bit seen;
        logic [29:0] a;
        logic [3:0]  b;
        logic [31:0] d;
        int n;
        stall_ok = 1; stable_ok = 1; seen = 0; req_cycles = 0; n = 0; got = 0;
        a = '0; b = '0; d = '0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (resp_valid) begin
                got = 1;
            end else begin
                if (!stall_o) stall_ok = 0;
                if (mem_req) begin
                    req_cycles++;
                    if (seen && (mem_addr != a || mem_wbe != b || mem_wdata != d)) stable_ok = 0;
                    seen = 1; a = mem_addr; b = mem_wbe; d = mem_wdata;
                end
                if (mem_ack) seen = 0;
            end
        end
        check({name, "_got_resp"}, 64'(got), 64'(1));
        check({name, "_stall_busy"}, 64'(stall_ok), 64'(1));
        check({name, "_fields_stable"}, 64'(stable_ok), 64'(1));
        if (got) check({name, "_stall_done"}, 64'(stall_o), 64'(0));
        req = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int  rc;
        bit  got;
        start_req(v.name, v.we, v.lt, v.ss, v.addr, v.wd, v.exp_rd, 1'b0, v.lat);
        wait_resp(v.name, rc, got);
        check({v.name, "_naccess"}, 64'(acc_q.size()), 64'(v.nacc));
        if (acc_q.size() >= 1) begin
            check({v.name, "_a0_addr"}, 64'(acc_q[0].addr), 64'(v.a0));
            check({v.name, "_a0_we"}, 64'(acc_q[0].we), 64'(v.we));
            check({v.name, "_a0_wbe"}, 64'(acc_q[0].wbe), 64'(v.be0));
            if (v.we) check({v.name, "_a0_wdata"}, 64'(acc_q[0].wdata), 64'(v.wd0));
        end
        if (acc_q.size() >= 2) begin
            check({v.name, "_a1_addr"}, 64'(acc_q[1].addr), 64'(v.a1));
            check({v.name, "_a1_wbe"}, 64'(acc_q[1].wbe), 64'(v.be1));
            if (v.we) check({v.name, "_a1_wdata"}, 64'(acc_q[1].wdata), 64'(v.wd1));
        end
        @(negedge clk);
        check({v.name, "_resp_pulse"}, 64'(resp_valid), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int  rc;
        bit  got;
        int  n;
        int  pulses;

        // name, we, lt, ss, addr, wd, exp_rd, lat, nacc, a0, be0, wd0, a1, be1, wd1
        vecs[0]  = '{"lw_100",  1'b0, LT_LW,  SS_NONE, 32'h100, 32'h0, 32'h88776655, 2, 1,
                     30'h40, 4'h0, 32'h0, 30'h0, 4'h0, 32'h0};
        vecs[1]  = '{"lh_103",  1'b0, LT_LH,  SS_NONE, 32'h103, 32'h0, 32'hFFFF9988, 3, 2,
                     30'h40, 4'h0, 32'h0, 30'h41, 4'h0, 32'h0};
        vecs[2]  = '{"lhu_103", 1'b0, LT_LHU, SS_NONE, 32'h103, 32'h0, 32'h00009988, 3, 2,
                     30'h40, 4'h0, 32'h0, 30'h41, 4'h0, 32'h0};
        vecs[3]  = '{"lb_107",  1'b0, LT_LB,  SS_NONE, 32'h107, 32'h0, 32'hFFFFFFCC, 2, 1,
                     30'h41, 4'h0, 32'h0, 30'h0, 4'h0, 32'h0};
        vecs[4]  = '{"lw_102",  1'b0, LT_LW,  SS_NONE, 32'h102, 32'h0, 32'hAA998877, 3, 2,
                     30'h40, 4'h0, 32'h0, 30'h41, 4'h0, 32'h0};
        vecs[5]  = '{"lbu_101", 1'b0, LT_LBU, SS_NONE, 32'h101, 32'h0, 32'h00000066, 2, 1,
                     30'h40, 4'h0, 32'h0, 30'h0, 4'h0, 32'h0};
        vecs[6]  = '{"lh_100",  1'b0, LT_LH,  SS_NONE, 32'h100, 32'h0, 32'h00006655, 2, 1,
                     30'h40, 4'h0, 32'h0, 30'h0, 4'h0, 32'h0};
        vecs[7]  = '{"lb_104",  1'b0, LT_LB,  SS_NONE, 32'h104, 32'h0, 32'hFFFFFF99, 2, 1,
                     30'h41, 4'h0, 32'h0, 30'h0, 4'h0, 32'h0};
        vecs[8]  = '{"lhu_106", 1'b0, LT_LHU, SS_NONE, 32'h106, 32'h0, 32'h0000CCBB, 2, 1,
                     30'h41, 4'h0, 32'h0, 30'h0, 4'h0, 32'h0};
        vecs[9]  = '{"lh_wrap", 1'b0, LT_LH,  SS_NONE, 32'hFFFFFFFF, 32'h0, 32'hFFFFEF12, 3, 2,
                     30'h3FFFFFFF, 4'h0, 32'h0, 30'h0, 4'h0, 32'h0};
        vecs[10] = '{"sw_101",  1'b1, LT_NONE, SS_SW, 32'h101, 32'h11223344, 32'h0, 3, 2,
                     30'h40, 4'b1110, 32'h22334400, 30'h41, 4'b0001, 32'h00000011};
        vecs[11] = '{"sh_102",  1'b1, LT_NONE, SS_SH, 32'h102, 32'hCAFEBEEF, 32'h0, 2, 1,
                     30'h40, 4'b1100, 32'hBEEF0000, 30'h0, 4'h0, 32'h0};
        vecs[12] = '{"sb_107",  1'b1, LT_NONE, SS_SB, 32'h107, 32'hFFFFFF5A, 32'h0, 2, 1,
                     30'h41, 4'b1000, 32'h5A000000, 30'h0, 4'h0, 32'h0};
        vecs[13] = '{"lw_100_after", 1'b0, LT_LW, SS_NONE, 32'h100, 32'h0, 32'hBEEF4455, 2, 1,
                     30'h40, 4'h0, 32'h0, 30'h0, 4'h0, 32'h0};
        vecs[14] = '{"lw_104_after", 1'b0, LT_LW, SS_NONE, 32'h104, 32'h0, 32'h5ABBAA11, 2, 1,
                     30'h41, 4'h0, 32'h0, 30'h0, 4'h0, 32'h0};

        init_mem();
        rst = 1'b1;
        req = 1'b1; req_we = 1'b0; req_load_type = LT_LW; req_store_size = SS_NONE;
        req_addr = 32'h100; req_wdata = 32'h0;

        // Reset state, with a valid-looking request present that must not stall.
        repeat (2) @(negedge clk);
        check("rst_ctrl", 64'({stall_o, resp_valid, resp_err, mem_req, mem_we, mem_wbe}), 64'(0));
        check("rst_rdata", 64'(resp_rdata), 64'(0));
        check("rst_addr", 64'(mem_addr), 64'(0));
        check("rst_wdata", 64'(mem_wdata), 64'(0));
        req = 1'b0;
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Invalid combinations are no-ops: no stall, no access, no response.
        @(posedge clk); #1;
        acc_q.delete();
        req = 1'b1; req_we = 1'b0; req_load_type = LT_NONE; req_addr = 32'h100;
        @(negedge clk);
        check("noop_load_stall", 64'(stall_o), 64'(0));
        @(posedge clk); #1;
        req_we = 1'b1; req_store_size = SS_NONE;
        @(negedge clk);
        check("noop_store_stall", 64'(stall_o), 64'(0));
        @(posedge clk); #1;
        req_we = 1'b0; req_load_type = 3'd6;
        @(negedge clk);
        check("noop_lt6_stall", 64'(stall_o), 64'(0));
        req = 1'b0;
        repeat (3) @(negedge clk);
        check("noop_naccess", 64'(acc_q.size()), 64'(0));

        // Delayed ack: three wait cycles, request held four cycles.
        init_mem();
        ack_delay = 3;
        start_req("lw_delay", 1'b0, LT_LW, SS_NONE, 32'h100, 32'h0, 32'h88776655, 1'b0, 5);
        wait_resp("lw_delay", rc, got);
        check("lw_delay_req_cycles", 64'(rc), 64'(4));
        check("lw_delay_naccess", 64'(acc_q.size()), 64'(1));
        ack_delay = 0;

        // Timeout: no ack at all gives an error response with zero data.
        no_ack = 1;
        start_req("lw_timeout", 1'b0, LT_LW, SS_NONE, 32'h100, 32'h0, 32'h0, 1'b1, -1);
        wait_resp("lw_timeout", rc, got);
        check("lw_timeout_req_cycles_ok",
              64'((rc >= int'(TIMEOUT)) && (rc <= int'(TIMEOUT) + 1)), 64'(1));
        @(negedge clk);
        check("lw_timeout_req_dropped", 64'(mem_req), 64'(0));
        no_ack = 0;

        // Reset while the second word is pending: outputs drop at once, no response.
        nak_en = 1; nak_addr = 30'h41;
        start_req("lw_rst", 1'b0, LT_LW, SS_NONE, 32'h102, 32'h0, 32'h0, 1'b0, -1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_req && mem_addr == 30'h41) && n < 20);
        check("rst_acc1_reached", 64'(mem_req && mem_addr == 30'h41), 64'(1));
        #1 rst = 1'b1;
        #1;
        check("rst_acc1_mem_req", 64'(mem_req), 64'(0));
        check("rst_acc1_stall", 64'(stall_o), 64'(0));
        sb_q.delete();
        req = 1'b0;
        nak_en = 0;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        check("rst_no_resp", 64'(pulses), 64'(0));

        // A fresh load after the abort completes normally.
        run_vec(vecs[0]);

        repeat (2) @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences MEM-stage loads and stores onto a word-organised data memory that uses a req/ack handshake.
- Splits any access that crosses a word boundary into two word accesses and merges the returned bytes.
- Returns a sign- or zero-extended result and stalls the pipeline until the access completes.
- Sits between the MEM-stage registers/hazard unit and the data memory port.

Parameters:
- ADDR_W, 32: byte-address width; the memory word address is ADDR_W-2 bits.
- TIMEOUT, 255: maximum cycles to wait for mem_ack per access; 0 disables the timeout.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; asynchronous, active-high.
- req  in  1  MEM-stage access request; held while stall_o=1.
- req_we  in  1  1=store, 0=load.
- req_load_type  in  3  load mode (Parameters.v): NOREGWRITE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5.
- req_store_size  in  2  store size: 0=none, SB=1, SH=2, SW=3.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- stall_o  out  1  stall request to the hazard unit.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result; 0 for stores and on error.
- resp_err  out  1  asserted together with resp_valid on timeout.
- mem_req  out  1  memory request; held until ack.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W-2  word address.
- mem_wbe  out  4  byte write enables.
- mem_wdata  out  32  lane-aligned write data.
- mem_ack  in  1  one-cycle acknowledge; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  read word.

Behaviour:
- Reset: state=IDLE. stall_o, resp_valid, resp_err, mem_req and mem_we are 0. resp_rdata, mem_addr, mem_wbe and mem_wdata are 0.
- Reset asserted mid-operation: all outputs drop to reset values immediately (asynchronous). The in-flight access is abandoned and no response is issued.
- Valid request:
  - A store is req=1, req_we=1, req_store_size!=0.
  - A load is req=1, req_we=0, req_load_type in 1..5.
  - Any other combination is a no-op: no stall and no memory access.
- Width in bytes: SB/LB/LBU=1, SH/LH/LHU=2, SW/LW=4. off = req_addr[1:0]. be8 = (width mask) << off. Store data: wd64 = {32'b0, wdata} << (8*off).
- A second access is needed iff be8[7:4]!=0. Halfwords and words may be misaligned; no alignment exception is raised.
- FSM states: IDLE, ACC0, ACC1, DONE.
  - IDLE: on a valid request, latch the request fields, load the timeout counter, and go to ACC0. stall_o is combinational = valid request in IDLE, OR state in {ACC0, ACC1}.
  - ACC0: mem_req=1, mem_addr=req_addr[ADDR_W-1:2], mem_wbe=be8[3:0] (stores; 0 for loads), mem_wdata=wd64[31:0] with unused lanes 0.
    - On mem_ack: latch rdata0, then go to ACC1 if a second access is needed, else DONE.
  - ACC1: mem_req=1, mem_addr=previous word address + 1 (wraps modulo 2^(ADDR_W-2)), mem_wbe=be8[7:4], mem_wdata=wd64[63:32].
    - On mem_ack: latch rdata1, go to DONE.
  - DONE: resp_valid=1, stall_o=0 (the pipeline advances this cycle), then go to IDLE. A req seen in the following IDLE cycle is a new request.
- Load result: ({rdata1, rdata0} >> 8*off)[31:0], then extended per load type: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
- Timing with zero-wait memory (ack in the first mem_req cycle):
  - Aligned access: accept at cycle 0, memory at cycle 1, resp_valid at cycle 2.
  - Split access: resp_valid at cycle 3.
  - Each wait cycle adds one.
- mem_addr, mem_we, mem_wbe and mem_wdata are registered and stable for every cycle mem_req=1.
- Timeout (TIMEOUT>0): the counter decrements each cycle in ACC0/ACC1 without ack.
  - At zero: drop mem_req, go to DONE with resp_err=1 and resp_rdata=0.
  - A store that has already written its first half is not rolled back.
- mem_ack outside ACC0/ACC1 is ignored.

Decomposition:
- Parameters.v (shared include) gains: store-size defines (SB/SH/SW), FSM state encodings, and byte-width constants. The load-type defines already live there.
- One combinational sub-module, dmem_lane_merge: takes {rdata1, rdata0}, off and load type, and produces the extended 32-bit result.

Test Plan:
- Memory contents for all tests: word 0x40 (byte address 0x100) = 0x88776655, word 0x41 = 0xCCBBAA99.
- LW @0x100, zero-wait -> one access to addr 0x40; resp_valid at cycle 2; rdata=0x88776655; stall_o high for cycles 0-1 only.
- LH @0x103 -> accesses to 0x40 then 0x41; rdata=0xFFFF9988. Same access as LHU -> 0x00009988. LB @0x107 -> 0xFFFFFFCC.
- LW @0x102 -> two accesses; rdata=0xAA998877; resp_valid at cycle 3.
- SW 0x11223344 @0x101 -> access0: addr 0x40, wbe=1110, wdata=0x22334400. access1: addr 0x41, wbe=0001, wdata=0x00000011.
- LW @0x100 with mem_ack delayed 3 cycles -> mem_req and fields stable for 4 cycles; resp_valid 1 cycle after ack.
- With TIMEOUT=4 and no ack -> resp_valid=1, resp_err=1, rdata=0.
- Reset asserted in ACC1 -> mem_req and stall_o drop in the same cycle; no resp_valid.
- A new LW issued in the next cycle completes normally.
